// File: rtl/pulse_burst_pkg.sv
// Shared types and helpers for the pulse burst controller.
// Build option: PULSE_BURST_CONTINUOUS_EN (see pulse_burst_ctrl.sv).
package pulse_burst_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int BURST_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A burst is runnable when the high time is at least one cycle, the low
   // time is at least one cycle (P > W) and the pulse count is non-zero,
   // unless zero is allowed as the "endless" encoding. Callers zero-extend.
   function automatic logic cfg_valid(input logic [31:0] period,
                                      input logic [31:0] width,
                                      input logic [31:0] count,
                                      input logic        allow_zero_count);
      return (width != 32'd0) && (period > width) &&
             (allow_zero_count || (count != 32'd0));
   endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// Loadable modulo-P phase counter for the pulse burst controller.
// The phase register holds the phase of the current cycle; 'high' reports
// whether the phase of the following cycle falls inside the high window,
// so a registered pulse output driven from it lines up with 'phase'.
module pulse_phase_counter
   import pulse_burst_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] width,
   output logic             wrap,
   output logic             high
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] phase;
   logic [CNT_W-1:0] phase_nxt;

   assign wrap = en && (phase == (period - ONE));

   // Next phase: clear wins, then wrap to zero, otherwise count while enabled.
   always_comb begin
      phase_nxt = phase;
      if (clr) begin
         phase_nxt = '0;
      end else if (wrap) begin
         phase_nxt = '0;
      end else if (en) begin
         phase_nxt = phase + ONE;
      end
   end

   assign high = (phase_nxt < width);

   // Phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
      end else begin
         phase <= phase_nxt;
      end
   end

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Programmable pulse burst sequencer: N pulses, W cycles high, every P cycles.
// Build option PULSE_BURST_CONTINUOUS_EN: when defined, cfg_count = 0 is an
// accepted endless burst that runs until stop (pulse_idx wraps, no done).
// When undefined, cfg_count = 0 is rejected with cfg_err.
module pulse_burst_ctrl
   import pulse_burst_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [CNT_W-1:0]   cfg_width,
   input  logic [BURST_W-1:0] cfg_count,
   output logic               pulse_out,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [BURST_W-1:0] pulse_idx
);

`ifdef PULSE_BURST_CONTINUOUS_EN
   localparam logic ALLOW_ZERO_COUNT = 1'b1;
`else
   localparam logic ALLOW_ZERO_COUNT = 1'b0;
`endif

   localparam logic [BURST_W-1:0] IDX_ONE = BURST_W'(1);

   state_t             state;
   logic [CNT_W-1:0]   period_q;
   logic [CNT_W-1:0]   width_q;
   logic [BURST_W-1:0] count_q;

   logic cfg_ok;
   logic last_pulse;
   logic wrap;
   logic high;
   logic cnt_en;
   logic cnt_clr;

   assign cfg_ok = cfg_valid(32'(cfg_period), 32'(cfg_width), 32'(cfg_count),
                             ALLOW_ZERO_COUNT);

`ifdef PULSE_BURST_CONTINUOUS_EN
   // A latched count of zero never terminates the burst.
   assign last_pulse = (count_q != '0) && (pulse_idx == count_q);
`else
   assign last_pulse = (pulse_idx == count_q);
`endif

   // Counter only advances in RUN; any abort or non-RUN cycle parks it at 0
   // so the next accepted start begins on phase 0.
   assign cnt_en  = (state == RUN);
   assign cnt_clr = (state != RUN) || stop;

   pulse_phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .period (period_q),
      .width  (width_q),
      .wrap   (wrap),
      .high   (high)
   );

   // Control FSM with registered status and pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         period_q  <= '0;
         width_q   <= '0;
         count_q   <= '0;
         pulse_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         pulse_idx <= '0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               pulse_out <= 1'b0;
               busy      <= 1'b0;
               // stop has priority over a simultaneous start
               if (start && !stop) begin
                  if (cfg_ok) begin
                     period_q  <= cfg_period;
                     width_q   <= cfg_width;
                     count_q   <= cfg_count;
                     state     <= RUN;
                     busy      <= 1'b1;
                     pulse_out <= 1'b1;   // W >= 1, so phase 0 is always high
                     pulse_idx <= IDX_ONE;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  pulse_out <= 1'b0;
               end else if (wrap && last_pulse) begin
                  state     <= DONE;
                  pulse_out <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  pulse_out <= high;
                  if (wrap) begin
                     pulse_idx <= pulse_idx + IDX_ONE;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               pulse_out <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               pulse_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Directed bench for pulse_burst_ctrl: expected output records are queued as
// each cycle's stimulus is applied and checked one clock later.
module tb_pulse_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [15:0] cfg_period = '0;
   logic [15:0] cfg_width = '0;
   logic [7:0]  cfg_count = '0;
   logic        pulse_out;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic [7:0]  pulse_idx;

   typedef struct packed {
      logic       pulse;
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] idx;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   pulse_burst_ctrl #(
      .CNT_W   (16),
      .BURST_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .cfg_period (cfg_period),
      .cfg_width  (cfg_width),
      .cfg_count  (cfg_count),
      .pulse_out  (pulse_out),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err),
      .pulse_idx  (pulse_idx)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic pl, input logic bz, input logic dn,
                               input logic er, input int idx);
      exp_t e;
      e.pulse = pl;
      e.busy  = bz;
      e.done  = dn;
      e.err   = er;
      e.idx   = 8'(idx);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " pulse_out"}, 32'(pulse_out), 32'(e.pulse));
         chk({tag, " busy"},      32'(busy),      32'(e.busy));
         chk({tag, " done"},      32'(done),      32'(e.done));
         chk({tag, " cfg_err"},   32'(cfg_err),   32'(e.err));
         chk({tag, " pulse_idx"}, 32'(pulse_idx), 32'(e.idx));
      end
   endtask

   // Apply one cycle of stimulus, queue what the next cycle must show, check it.
   task automatic cycle(input string tag, input logic st, input logic sp,
                        input int p, input int w, input int n, input exp_t e);
      start      = st;
      stop       = sp;
      cfg_period = 16'(p);
      cfg_width  = 16'(w);
      cfg_count  = 8'(n);
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      check_outputs(tag);
   endtask

   // Burst started in cycle 0. Cycle c shows phase index c-1 of the burst.
   // Optional stop in cycle stop_at, optional ignored re-start (with other
   // cfg values, held from then on) in cycle restart_at. n == 0 is endless.
   task automatic run_burst(input string name, input int p, input int w, input int n,
                            input int stop_at, input int restart_at, input int total);
      exp_t e;
      int   cyc, k, ph, sp_idx;
      int   dp, dw, dn;
      logic st, sp;
      for (int c = 1; c <= total; c++) begin
         cyc = c - 1;
         st  = (cyc == 0) || (cyc == restart_at);
         sp  = (cyc == stop_at);
         if (restart_at >= 0 && cyc >= restart_at) begin
            dp = p + 3; dw = w + 1; dn = n + 2;
         end else begin
            dp = p; dw = w; dn = n;
         end
         k  = cyc / p;
         ph = cyc % p;
         if (stop_at >= 0 && cyc >= stop_at) begin
            sp_idx = ((stop_at - 1) / p + 1) % 256;
            e = mk(1'b0, 1'b0, 1'b0, 1'b0, sp_idx);
         end else if (n == 0 || cyc < n * p) begin
            e = mk(ph < w, 1'b1, 1'b0, 1'b0, (k + 1) % 256);
         end else if (cyc == n * p) begin
            e = mk(1'b0, 1'b1, 1'b1, 1'b0, n);
         end else begin
            e = mk(1'b0, 1'b0, 1'b0, 1'b0, n);
         end
         cycle($sformatf("%s c%0d", name, c), st, sp, dp, dw, dn, e);
      end
   endtask

   // A rejected start pulses cfg_err once and leaves everything else alone.
   task automatic check_invalid(input string name, input int p, input int w,
                                input int n, input int idx);
      cycle({name, " err"},  1'b1, 1'b0, p, w, n, mk(1'b0, 1'b0, 1'b0, 1'b1, idx));
      cycle({name, " post"}, 1'b0, 1'b0, p, w, n, mk(1'b0, 1'b0, 1'b0, 1'b0, idx));
      cycle({name, " idle"}, 1'b0, 1'b0, p, w, n, mk(1'b0, 1'b0, 1'b0, 1'b0, idx));
   endtask

   initial begin
      // reset state
      #1;
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
      check_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle("idle", 1'b0, 1'b0, 4, 1, 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));

      // P=4 W=1 N=3 with an ignored re-start carrying different cfg
      run_burst("p4w1n3", 4, 1, 3, -1, 4, 16);
      // P=5 W=3 N=2, back-to-back periods
      run_burst("p5w3n2", 5, 3, 2, -1, -1, 13);

      // rejected configurations
      check_invalid("w0",   4, 0, 2, 2);
      check_invalid("p_eq_w", 4, 4, 2, 2);
      check_invalid("w_gt_p", 3, 5, 2, 2);
`ifndef PULSE_BURST_CONTINUOUS_EN
      check_invalid("n0",   4, 1, 0, 2);
`endif

      // start and stop together while idle: nothing happens
      cycle("st_sp", 1'b1, 1'b1, 4, 1, 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 2));
      cycle("st_sp post", 1'b0, 1'b0, 4, 1, 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 2));

      // abort in the middle of the first high phase
      run_burst("abort", 10, 6, 4, 3, -1, 8);

      // asynchronous reset in the middle of a burst
      run_burst("pre_rst", 4, 1, 3, -1, -1, 6);
      #3;
      rst_n = 1'b0;
      #1;
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
      check_outputs("async_rst");
      @(posedge clk);
      #1;
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
      check_outputs("rst_held");
      rst_n = 1'b1;
      run_burst("after_rst", 4, 1, 3, -1, -1, 16);

`ifdef PULSE_BURST_CONTINUOUS_EN
      // endless burst past 256 pulses, ended by stop
      run_burst("endless", 3, 1, 0, 800, -1, 803);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
